tournament_predictor: RTL and testbench

TOURNAMENT_PREDICTOR -- requirements
Module: tournament_predictor

---
 rtl/bp_pkg.sv | 36 +++
 rtl/bp_pht.sv | 33 +++
 rtl/tournament_predictor.sv | 147 ++++++++++++++
 tb/tb_tournament_predictor.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the tournament branch predictor: 2-bit counters,
// pred_info field layout and the saturating counter step.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_INIT = 2'b01;

    // Default global history width; pred_info_t describes the default-sized bundle
    localparam int unsigned GHR_W_DEF = 4;

    typedef struct packed {
        logic [GHR_W_DEF-1:0] ghr_snapshot;
        logic                 local_pred;
        logic                 global_pred;
        logic                 choice;
    } pred_info_t;

    // Bit positions inside the pred_info bundle, valid for any GHR width
    localparam int unsigned INFO_CHOICE   = 0;
    localparam int unsigned INFO_GLOBAL   = 1;
    localparam int unsigned INFO_LOCAL    = 2;
    localparam int unsigned INFO_SNAP_LSB = 3;

    function automatic ctr_t ctr_step(input ctr_t c, input logic up);
        ctr_t r;
        r = c;
        if (up) begin
            if (c != 2'b11) r = ctr_t'(c + 2'b01);
        end else begin
            if (c != 2'b00) r = ctr_t'(c - 2'b01);
        end
        return r;
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Table of 2-bit saturating counters: one asynchronous read port and one
// synchronous read-modify-write update port; no write-to-read bypass.
module bp_pht
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output ctr_t             o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_up
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    ctr_t r_mem [DEPTH];

    assign o_rd_ctr = r_mem[i_rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= CTR_INIT;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= ctr_step(r_mem[i_wr_idx], i_wr_up);
        end
    end

endmodule

// File: rtl/tournament_predictor.sv
// Tournament predictor: gshare global PHT, per-PC local history PHT and a
// chooser; speculative GHR with restore from the fetch-time snapshot on mispredict.
module tournament_predictor
    import bp_pkg::*;
#(
    parameter int unsigned GHR_W     = 4,
    parameter int unsigned BHT_DEPTH = 3,
    parameter int unsigned BHR_W     = 4,
    parameter int unsigned INFO_W    = GHR_W + 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pred_pc_i,
    output logic              pred_taken_o,
    output logic [INFO_W-1:0] pred_info_o,
    input  logic              spec_valid_i,
    input  logic              spec_taken_i,
    input  logic              upd_valid_i,
    input  logic [31:0]       upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [INFO_W-1:0] upd_info_i,
    output logic              mispredict_o
);

    localparam int unsigned LPHT_W = BHT_DEPTH + BHR_W;
    localparam int unsigned BHT_N  = 1 << BHT_DEPTH;

    logic [GHR_W-1:0] r_ghr;
    logic [BHR_W-1:0] r_bhr [BHT_N];

    // Fetch-side lookup
    logic [GHR_W-1:0]     w_pred_gidx;
    logic [BHT_DEPTH-1:0] w_pred_bidx;
    logic [LPHT_W-1:0]    w_pred_lidx;
    ctr_t                 w_g_ctr;
    ctr_t                 w_l_ctr;
    ctr_t                 w_c_ctr;
    logic                 w_global_pred;
    logic                 w_local_pred;
    logic                 w_choice;

    assign w_pred_gidx = r_ghr ^ pred_pc_i[GHR_W+1:2];
    assign w_pred_bidx = pred_pc_i[BHT_DEPTH+1:2];
    assign w_pred_lidx = {w_pred_bidx, r_bhr[w_pred_bidx]};

    assign w_global_pred = w_g_ctr[1];
    assign w_local_pred  = w_l_ctr[1];
    assign w_choice      = w_c_ctr[1];

    assign pred_taken_o = w_choice ? w_local_pred : w_global_pred;
    assign pred_info_o  = {r_ghr, w_local_pred, w_global_pred, w_choice};

    // Resolve-side decode of the bundle captured at fetch
    logic [GHR_W-1:0]     w_upd_snap;
    logic                 w_upd_local;
    logic                 w_upd_global;
    logic                 w_upd_choice;
    logic                 w_upd_final;
    logic [GHR_W-1:0]     w_upd_gidx;
    logic [BHT_DEPTH-1:0] w_upd_bidx;
    logic [BHR_W-1:0]     w_upd_bhr;
    logic [LPHT_W-1:0]    w_upd_lidx;
    logic                 w_chooser_en;
    logic                 w_chooser_up;

    assign w_upd_snap   = upd_info_i[INFO_SNAP_LSB +: GHR_W];
    assign w_upd_local  = upd_info_i[INFO_LOCAL];
    assign w_upd_global = upd_info_i[INFO_GLOBAL];
    assign w_upd_choice = upd_info_i[INFO_CHOICE];
    assign w_upd_final  = w_upd_choice ? w_upd_local : w_upd_global;

    assign mispredict_o = upd_valid_i & (upd_taken_i ^ w_upd_final);

    assign w_upd_gidx = w_upd_snap ^ upd_pc_i[GHR_W+1:2];
    assign w_upd_bidx = upd_pc_i[BHT_DEPTH+1:2];
    assign w_upd_bhr  = r_bhr[w_upd_bidx];
    assign w_upd_lidx = {w_upd_bidx, w_upd_bhr};

    // Chooser only learns when the two components disagreed
    assign w_chooser_en = upd_valid_i & (w_upd_local ^ w_upd_global);
    assign w_chooser_up = (w_upd_local == upd_taken_i);

    bp_pht #(.IDX_W(GHR_W)) u_global_pht (
        .clk      (clk),
        .rst      (rst),
        .i_rd_idx (w_pred_gidx),
        .o_rd_ctr (w_g_ctr),
        .i_wr_en  (upd_valid_i),
        .i_wr_idx (w_upd_gidx),
        .i_wr_up  (upd_taken_i)
    );

    bp_pht #(.IDX_W(LPHT_W)) u_local_pht (
        .clk      (clk),
        .rst      (rst),
        .i_rd_idx (w_pred_lidx),
        .o_rd_ctr (w_l_ctr),
        .i_wr_en  (upd_valid_i),
        .i_wr_idx (w_upd_lidx),
        .i_wr_up  (upd_taken_i)
    );

    bp_pht #(.IDX_W(GHR_W)) u_chooser (
        .clk      (clk),
        .rst      (rst),
        .i_rd_idx (w_pred_gidx),
        .o_rd_ctr (w_c_ctr),
        .i_wr_en  (w_chooser_en),
        .i_wr_idx (w_upd_gidx),
        .i_wr_up  (w_chooser_up)
    );

    // Mispredict restore wins over a same-cycle speculative shift
    logic [GHR_W-1:0] w_ghr_next;

    always_comb begin
        w_ghr_next = r_ghr;
        if (mispredict_o) begin
            w_ghr_next = {w_upd_snap[GHR_W-2:0], upd_taken_i};
        end else if (spec_valid_i) begin
            w_ghr_next = {r_ghr[GHR_W-2:0], spec_taken_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ghr <= '0;
        end else begin
            r_ghr <= w_ghr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_N; i++) begin
                r_bhr[i] <= '0;
            end
        end else if (upd_valid_i) begin
            r_bhr[w_upd_bidx] <= {w_upd_bhr[BHR_W-2:0], upd_taken_i};
        end
    end

    // Only a few PC bits index the tables
    logic w_unused_pc;
    assign w_unused_pc = ^{pred_pc_i, upd_pc_i};

endmodule

// File: tb/tb_tournament_predictor.sv
// Directed table-driven bench for tournament_predictor with hand-computed
// predictions, info bundles and mispredict flags, plus a mid-run reset sequence.
module tb_tournament_predictor;

    localparam logic [31:0] PC_A = 32'h0040_0010;
    localparam logic [31:0] PC_B = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pred_pc_i;
    logic        pred_taken_o;
    logic [6:0]  pred_info_o;
    logic        spec_valid_i;
    logic        spec_taken_i;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [6:0]  upd_info_i;
    logic        mispredict_o;

    always #5 clk = ~clk;

    tournament_predictor dut (
        .clk          (clk),
        .rst          (rst),
        .pred_pc_i    (pred_pc_i),
        .pred_taken_o (pred_taken_o),
        .pred_info_o  (pred_info_o),
        .spec_valid_i (spec_valid_i),
        .spec_taken_i (spec_taken_i),
        .upd_valid_i  (upd_valid_i),
        .upd_pc_i     (upd_pc_i),
        .upd_taken_i  (upd_taken_i),
        .upd_info_i   (upd_info_i),
        .mispredict_o (mispredict_o)
    );

    typedef struct {
        logic        spec_v;
        logic        spec_t;
        logic        upd_v;
        logic [31:0] upd_pc;
        logic        upd_t;
        logic [6:0]  upd_info;
        logic [31:0] pred_pc;
        logic        exp_taken;
        logic [6:0]  exp_info;
        logic        exp_mis;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic sv, input logic st, input logic uv,
                                input logic [31:0] upc, input logic ut, input logic [6:0] uinfo,
                                input logic [31:0] ppc, input logic et, input logic [6:0] ei,
                                input logic em);
        vec_t v;
        v.spec_v = sv;  v.spec_t = st;  v.upd_v = uv;
        v.upd_pc = upc; v.upd_t = ut;   v.upd_info = uinfo;
        v.pred_pc = ppc;
        v.exp_taken = et; v.exp_info = ei; v.exp_mis = em;
        return v;
    endfunction

    task automatic clear_inputs();
        spec_valid_i = 1'b0;
        spec_taken_i = 1'b0;
        upd_valid_i  = 1'b0;
        upd_pc_i     = 32'h0;
        upd_taken_i  = 1'b0;
        upd_info_i   = 7'h00;
        pred_pc_i    = PC_A;
    endtask

    initial begin
        // Expectations are for the cycle in which the row is applied (pre-update state)
        // training on PC_A: global counter 01->10->11->11, then a not-taken pulls it to 10
        vecs[0]  = mk(0, 0, 0, PC_A, 0, 7'h00, PC_A, 0, 7'h00, 0);
        vecs[1]  = mk(0, 0, 1, PC_A, 1, 7'h02, PC_A, 0, 7'h00, 0);
        vecs[2]  = mk(0, 0, 1, PC_A, 1, 7'h02, PC_A, 1, 7'h02, 0);
        vecs[3]  = mk(0, 0, 0, PC_A, 0, 7'h00, PC_A, 1, 7'h02, 0);
        vecs[4]  = mk(0, 0, 1, PC_A, 1, 7'h02, PC_A, 1, 7'h02, 0);
        vecs[5]  = mk(0, 0, 1, PC_A, 0, 7'h02, PC_A, 1, 7'h02, 1);
        vecs[6]  = mk(0, 0, 0, PC_A, 0, 7'h00, PC_A, 1, 7'h02, 0);
        // speculative shifts 0,1,0,1 build GHR=0101, visible in the snapshot field
        vecs[7]  = mk(1, 0, 0, PC_B, 0, 7'h00, PC_B, 0, 7'h00, 0);
        vecs[8]  = mk(1, 1, 0, PC_B, 0, 7'h00, PC_B, 0, 7'h00, 0);
        vecs[9]  = mk(1, 0, 0, PC_B, 0, 7'h00, PC_B, 0, 7'h08, 0);
        vecs[10] = mk(1, 1, 0, PC_B, 0, 7'h00, PC_B, 0, 7'h10, 0);
        vecs[11] = mk(0, 0, 0, PC_B, 0, 7'h00, PC_B, 0, 7'h28, 0);
        // recovery: snapshot 0101, predicted 0, actual 1 -> GHR 1011
        vecs[12] = mk(0, 0, 1, PC_B, 1, 7'h28, PC_B, 0, 7'h28, 1);
        vecs[13] = mk(0, 0, 0, PC_B, 0, 7'h00, PC_B, 0, 7'h58, 0);
        // collision: spec shift of 0 with mispredict on snapshot 0011 -> GHR 0111 only
        vecs[14] = mk(1, 0, 1, PC_B, 1, 7'h18, PC_B, 0, 7'h58, 1);
        vecs[15] = mk(0, 0, 0, PC_B, 0, 7'h00, PC_B, 0, 7'h38, 0);
        // chooser flip at index 7: local right, global wrong, twice
        vecs[16] = mk(0, 0, 1, PC_B, 1, 7'h3D, PC_B, 0, 7'h38, 0);
        vecs[17] = mk(0, 0, 1, PC_B, 1, 7'h3D, PC_B, 0, 7'h3B, 0);
        // update fields driven with upd_valid low must not disturb anything
        vecs[18] = mk(0, 0, 0, PC_B, 1, 7'h28, PC_B, 0, 7'h3B, 0);
        vecs[19] = mk(0, 0, 0, PC_B, 0, 7'h00, PC_B, 0, 7'h3B, 0);
        vecs[20] = mk(0, 0, 0, PC_A, 0, 7'h00, PC_A, 1, 7'h3A, 0);

        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            spec_valid_i = vecs[i].spec_v;
            spec_taken_i = vecs[i].spec_t;
            upd_valid_i  = vecs[i].upd_v;
            upd_pc_i     = vecs[i].upd_pc;
            upd_taken_i  = vecs[i].upd_t;
            upd_info_i   = vecs[i].upd_info;
            pred_pc_i    = vecs[i].pred_pc;
            #1;
            check($sformatf("vec%0d pred_taken", i), 32'(pred_taken_o), 32'(vecs[i].exp_taken));
            check($sformatf("vec%0d pred_info", i), 32'(pred_info_o), 32'(vecs[i].exp_info));
            check($sformatf("vec%0d mispredict", i), 32'(mispredict_o), 32'(vecs[i].exp_mis));
            @(posedge clk);
            #1;
        end

        // Mid-run reset while training and shifting: reset must dominate
        rst          = 1'b1;
        spec_valid_i = 1'b1;
        spec_taken_i = 1'b1;
        upd_valid_i  = 1'b1;
        upd_pc_i     = PC_A;
        upd_taken_i  = 1'b1;
        upd_info_i   = 7'h02;
        pred_pc_i    = PC_A;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_inputs();
        #1;
        check("reset pred_taken A", 32'(pred_taken_o), 32'd0);
        check("reset pred_info A", 32'(pred_info_o), 32'h00);
        check("reset mispredict", 32'(mispredict_o), 32'd0);
        pred_pc_i = PC_B;
        #1;
        check("reset pred_taken B", 32'(pred_taken_o), 32'd0);
        check("reset pred_info B", 32'(pred_info_o), 32'h00);
        @(posedge clk);
        #1;
        pred_pc_i = PC_A;
        #1;
        check("post reset idle A", 32'(pred_taken_o), 32'd0);
        check("post reset idle info", 32'(pred_info_o), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
